fpga_robots_game_serial_tx: RTL and testbench

UART transmitter that drives the board's serial_tx pin, replacing the current constant-high tie-off.
- Game logic pushes bytes into a small internal FIFO.
- The block serializes each byte as 8N1 (start, 8 data LSB first, stop) at a fixed divisor of the ~65 MHz system clock.
- It is the transmit counterpart to the host serial link on serial_rx. It is used for debug and status output to the host.

---
 rtl/fpga_robots_game_serial_tx_pkg.sv | 29 ++
 rtl/fpga_robots_game_fifo.sv | 84 ++++++++
 rtl/fpga_robots_game_serial_tx.sv | 197 +++++++++++++++++++
 tb/tb_fpga_robots_game_serial_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_robots_game_serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// fpga_robots_game_serial_tx_pkg
// Shared definitions for the serial transmit path of the robots game:
//   - FSM state encodings (3-bit constants, legacy-compatible)
//   - default baud divisor for a ~65 MHz system clock at 115200 baud
//   - number of data bits per frame
//   - even-parity helper
// The PARITY encoding is always defined. The transmitter only uses it when
// FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package fpga_robots_game_serial_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // 65 MHz / 115200 baud, rounded.
    localparam int DEFAULT_DIVISOR = 564;
    localparam int DATA_BITS       = 8;

    // Even parity: the XOR of the data bits, so that data plus parity holds
    // an even number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/fpga_robots_game_fifo.sv
// -----------------------------------------------------------------------------
// fpga_robots_game_fifo
// Parameterized synchronous first-word-fall-through FIFO. The memory is a
// register array. dout_o shows the head entry whenever count_o != 0. The read
// and write pointers are LG bits and wrap modulo the depth. The count is one
// bit wider, so full and empty are distinct. A push while full is refused,
// even when a pop happens in the same cycle. A pop while empty is ignored.
// Meant for reuse by the serial receiver and the PS/2 path.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (flushes the FIFO)
//   push_i   in   enqueue request
//   din_i    in   data to enqueue
//   pop_i    in   dequeue request
//   dout_o   out  head entry (valid when count_o != 0)
//   count_o  out  occupancy 0..2^LG
//   full_o   out  count_o == 2^LG
//   empty_o  out  count_o == 0
// -----------------------------------------------------------------------------
module fpga_robots_game_fifo #(
    parameter int WIDTH = 8,
    parameter int LG    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [LG:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << LG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LG-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LG-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LG:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (LG+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Acceptance depends on the current occupancy only. A full FIFO refuses
    // a push even while it is being popped in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset. Only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fpga_robots_game_serial_tx.sv
// -----------------------------------------------------------------------------
// fpga_robots_game_serial_tx
// UART transmitter for the board's serial_tx pin, used for debug and status
// output to the host. Game logic pushes bytes into an internal FIFO. Each
// byte is sent as 8N1 (start, 8 data bits LSB first, stop). Each bit lasts
// DIVISOR clocks. Back-to-back bytes are sent with no idle gap between frames.
//
// Optional feature:
//   FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN - when defined, an even parity bit is
//   inserted between the data bits and the stop bit, giving frame format 8E1.
//
// Parameters:
//   DIVISOR  clocks per bit (2..65535), default 564 (65 MHz / 115200)
//   FIFO_LG  log2 of FIFO depth, default 4 (16 bytes)
//
// Ports:
//   clk        in   system clock (~65 MHz)
//   rst        in   synchronous active-high reset
//   wr_dat     in   byte to enqueue
//   wr_stb     in   enqueue strobe, accepted only when wr_rdy=1
//   wr_rdy     out  FIFO not full
//   busy       out  frame on the line or FIFO non-empty
//   fifo_cnt   out  FIFO occupancy 0..2^FIFO_LG
//   serial_tx  out  registered serial line, idle high
//   dbg_state  out  current FSM state (encodings in the package)
// -----------------------------------------------------------------------------
module fpga_robots_game_serial_tx
    import fpga_robots_game_serial_tx_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int FIFO_LG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         wr_dat,
    input  logic               wr_stb,
    output logic               wr_rdy,
    output logic               busy,
    output logic [FIFO_LG:0]   fifo_cnt,
    output logic               serial_tx,
    output logic [2:0]         dbg_state
);

    localparam logic [15:0] DIV_M1   = 16'(DIVISOR - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;

    fpga_robots_game_fifo #(
        .WIDTH (8),
        .LG    (FIFO_LG)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_stb),
        .din_i   (wr_dat),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_rdy    = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign serial_tx = tx_q;
    assign dbg_state = state_q;

    // tx_d is the line level for the state being entered. The line then
    // changes on the same edge as the state, and serial_tx stays a plain flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = DIV_M1;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = DIV_M1;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = DIV_M1;
                    if (bit_q == LAST_BIT) begin
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Bit 0 of shift_q is always the bit on the line now.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_q == 16'd0) begin
                    baud_d  = DIV_M1;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == 16'd0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop      = 1'b1;
                        shift_d  = fifo_dout;
                        baud_d   = DIV_M1;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
                        parity_d = even_parity(fifo_dout);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpga_robots_game_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fpga_robots_game_serial_tx
// Bench for fpga_robots_game_serial_tx with DIVISOR=4 and FIFO_LG=4.
// Accepted bytes go into an expected queue when they are driven. A line
// monitor pops one entry at each start bit and compares the whole frame
// against the model, cycle by cycle. Frame length follows
// FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_fpga_robots_game_serial_tx;

    localparam int D       = 4;
    localparam int FIFO_LG = 4;
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * D;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       wr_dat = 8'd0;
    logic             wr_stb = 1'b0;
    logic             wr_rdy;
    logic             busy;
    logic [FIFO_LG:0] fifo_cnt;
    logic             serial_tx;
    logic [2:0]       dbg_state;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;

    logic [7:0]       exp_q[$];
    int               start_q[$];

    bit               mon_active = 1'b0;
    int               mon_cnt = 0;
    logic [7:0]       mon_byte = 8'd0;

    fpga_robots_game_serial_tx #(
        .DIVISOR (D),
        .FIFO_LG (FIFO_LG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_dat    (wr_dat),
        .wr_stb    (wr_stb),
        .wr_rdy    (wr_rdy),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt),
        .serial_tx (serial_tx),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FPGA_ROBOTS_GAME_SERIAL_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // ---------------- line monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && serial_tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_eq("frame_unexpected", 32'd1, 32'd0);
                    mon_byte = 8'd0;
                end else begin
                    mon_byte = exp_q.pop_front();
                end
            end
            if (mon_active) begin
                check_eq($sformatf("line_%02h_b%0d", mon_byte, mon_cnt / D),
                         {31'd0, serial_tx}, {31'd0, frame_bit(mon_byte, mon_cnt / D)});
                if (mon_cnt == FRAME_LEN - 1) mon_active = 1'b0;
                else mon_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered and left 1 time unit after a rising edge.
    task automatic drive_push(input logic [7:0] d, input bit accept);
        wr_dat = d;
        wr_stb = 1'b1;
        if (accept) exp_q.push_back(d);
        @(posedge clk); #1;
        wr_stb = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_until_cyc(input int t);
        if (t < cyc) check_eq("target_in_past", cyc, t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((busy || mon_active || exp_q.size() != 0) && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= limit) check_eq("idle_timeout", 32'd0, 32'd1);
        step(2);
        check_eq("idle_line", {31'd0, serial_tx}, 32'd1);
        check_eq("idle_cnt", {27'd0, fifo_cnt}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0, base, fall;

        // Reset values
        step(3);
        check_eq("rst_tx", {31'd0, serial_tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
        check_eq("rst_rdy", {31'd0, wr_rdy}, 32'd1);
        rst = 1'b0;
        step(2);

        // 1: single byte, latency, and when busy falls
        n0   = cyc;
        base = start_q.size();
        drive_push(8'h55, 1'b1);
        check_eq("t1_cnt_n1", {27'd0, fifo_cnt}, 32'd1);
        check_eq("t1_busy_n1", {31'd0, busy}, 32'd1);
        step(1);
        check_eq("t1_cnt_n2", {27'd0, fifo_cnt}, 32'd0);
        check_eq("t1_tx_n2", {31'd0, serial_tx}, 32'd0);
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            step(1);
        end
        fall = cyc;
        check_eq("t1_busy_fall", fall, n0 + 2 + FRAME_LEN);
        check_eq("t1_frames", start_q.size(), base + 1);
        if (start_q.size() > base) check_eq("t1_start_cyc", start_q[base], n0 + 2);
        wait_idle(200);

        // 2: three back-to-back bytes, no idle gap
        n0   = cyc;
        base = start_q.size();
        drive_push(8'hA3, 1'b1);
        check_eq("t2_cnt_n1", {27'd0, fifo_cnt}, 32'd1);
        drive_push(8'h00, 1'b1);
        drive_push(8'hFF, 1'b1);
        check_eq("t2_cnt_n3", {27'd0, fifo_cnt}, 32'd2);
        wait_idle(400);
        check_eq("t2_frames", start_q.size(), base + 3);
        if (start_q.size() >= base + 3) begin
            check_eq("t2_gap01", start_q[base+1] - start_q[base], FRAME_LEN);
            check_eq("t2_gap12", start_q[base+2] - start_q[base+1], FRAME_LEN);
        end

        // parity-sensitive pair (parity bits 1 then 0 under 8E1)
        drive_push(8'h07, 1'b1);
        drive_push(8'h03, 1'b1);
        wait_idle(400);

        // 3: fill the FIFO behind an in-flight frame, 17th byte is dropped
        drive_push(8'hC3, 1'b1);
        step(3);
        check_eq("t3_cnt_pre", {27'd0, fifo_cnt}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_eq("t3_rdy_fill", {31'd0, wr_rdy}, 32'd1);
            drive_push(8'(i), 1'b1);
        end
        check_eq("t3_cnt_full", {27'd0, fifo_cnt}, 32'd16);
        check_eq("t3_rdy_full", {31'd0, wr_rdy}, 32'd0);
        drive_push(8'h10, 1'b0);
        check_eq("t3_cnt_after_drop", {27'd0, fifo_cnt}, 32'd16);
        wait_idle(2000);

        // 6: push coinciding with the pop at the end of a stop bit, cnt=1
        n0 = cyc;
        drive_push(8'h5A, 1'b1);
        drive_push(8'h6B, 1'b1);
        wait_until_cyc(n0 + 2 + FRAME_LEN - 1);
        check_eq("t6_cnt_pre", {27'd0, fifo_cnt}, 32'd1);
        drive_push(8'h7C, 1'b1);
        check_eq("t6_cnt_post", {27'd0, fifo_cnt}, 32'd1);
        check_eq("t6_next_start", {31'd0, serial_tx}, 32'd0);
        wait_idle(400);

        // random bytes with random gaps (never enough to overflow)
        for (int i = 0; i < 8; i++) begin
            drive_push(8'($urandom_range(0, 255)), 1'b1);
            step($urandom_range(0, 50));
        end
        wait_idle(1000);

        // 4: reset during data bit 3 of 0x0F with three bytes queued
        n0   = cyc;
        drive_push(8'h0F, 1'b1);
        drive_push(8'h11, 1'b1);
        drive_push(8'h22, 1'b1);
        drive_push(8'h33, 1'b1);
        wait_until_cyc(n0 + 2 + 4 * D + 1);
        check_eq("t4_cnt_pre", {27'd0, fifo_cnt}, 32'd3);
        base   = start_q.size();
        rst    = 1'b1;
        wr_dat = 8'h99;
        wr_stb = 1'b1;
        step(1);
        check_eq("t4_tx_after_rst", {31'd0, serial_tx}, 32'd1);
        check_eq("t4_cnt_after_rst", {27'd0, fifo_cnt}, 32'd0);
        check_eq("t4_busy_after_rst", {31'd0, busy}, 32'd0);
        step(1);
        check_eq("t4_stb_ignored", {27'd0, fifo_cnt}, 32'd0);
        rst    = 1'b0;
        wr_stb = 1'b0;
        exp_q.delete();
        step(3 * FRAME_LEN);
        check_eq("t4_no_frames", start_q.size(), base);
        check_eq("t4_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t4_tx_end", {31'd0, serial_tx}, 32'd1);

        // transmitter still usable after reset
        drive_push(8'hE1, 1'b1);
        wait_idle(200);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
